// File: rtl/mlp_seq_accel_pkg.sv
// Shared types and helpers for the time-multiplexed two-layer MLP engine.
package mlp_seq_accel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L1_LOAD,
        ST_L1_MAC,
        ST_L2_MAC,
        ST_L2_DRAIN,
        ST_RESULT
    } state_t;

    // Layer-2 weights follow the IN_LEN x HID layer-1 block in weight memory.
    function automatic int unsigned l2_base(input int unsigned in_len, input int unsigned hid);
        return in_len * hid;
    endfunction

    function automatic logic [63:0] relu64(input logic signed [63:0] v);
        return v[63] ? '0 : v;
    endfunction

endpackage

// File: rtl/mlp_seq_accel_if.sv
// Pixel, weight, result and control signals of mlp_seq_accel grouped as one bundle.
interface mlp_seq_accel_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int WA_W   = 15,
    parameter int IDX_W  = 4
);
    logic              start;
    logic              busy;
    logic              img_valid;
    logic              img_ready;
    logic [DATA_W-1:0] img_data;
    logic [WA_W-1:0]   w_addr;
    logic [DATA_W-1:0] w_data;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic [IDX_W-1:0]  res_idx;
    logic              class_valid;
    logic [IDX_W-1:0]  class_idx;

    modport slave (
        input  start, img_valid, img_data, w_data, res_ready,
        output busy, img_ready, w_addr, res_valid, res_data, res_idx, class_valid, class_idx
    );

    modport master (
        output start, img_valid, img_data, w_data, res_ready,
        input  busy, img_ready, w_addr, res_valid, res_data, res_idx, class_valid, class_idx
    );

endinterface

// File: rtl/mlp_seq_accel_mac_unit.sv
// Single shared multiply-accumulate: full-width signed product, wrap-around add.
module mlp_seq_accel_mac_unit #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
) (
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [ACC_W-1:0]  acc_in,
    output logic signed [ACC_W-1:0]  acc_out
);
    logic signed [2*DATA_W-1:0] prod;

    always_comb begin
        prod    = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        acc_out = en ? acc_in + ACC_W'(prod) : acc_in;
    end

endmodule

// File: rtl/mlp_seq_accel.sv
// Time-multiplexed dense->ReLU->dense inference engine with one MAC and external weight memory.
// Optional argmax output enabled by defining MLP_ARGMAX_EN.
module mlp_seq_accel
    import mlp_seq_accel_pkg::*;
#(
    parameter int IN_LEN = 784,
    parameter int HID    = 32,
    parameter int OUT    = 10,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
) (
    input  logic          clk,
    input  logic          reset,
    mlp_seq_accel_if.slave bus
);
    localparam int WA_W  = $clog2(IN_LEN*HID + HID*OUT);
    localparam int IDX_W = (OUT > 1) ? $clog2(OUT) : 1;
    localparam int I_W   = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam int J_W   = (HID > 1) ? $clog2(HID) : 1;

    state_t                   state;
    logic [I_W-1:0]           i;
    logic [J_W-1:0]           j, acc_j;
    logic [IDX_W-1:0]         k, acc_k;
    logic [DATA_W-1:0]        x;
    logic                     acc_en, acc_l2;
    logic signed [ACC_W-1:0]  h [HID];
    logic signed [ACC_W-1:0]  o [OUT];
    logic signed [DATA_W-1:0] op_a;
    logic signed [ACC_W-1:0]  acc_sel, mac_out, o_first;

    function automatic logic [WA_W-1:0] l1_addr(input int unsigned ii, input int unsigned jj);
        return WA_W'(ii*HID + jj);
    endfunction

    function automatic logic [WA_W-1:0] l2_addr(input int unsigned jj, input int unsigned kk);
        return WA_W'(l2_base(IN_LEN, HID) + jj*OUT + kk);
    endfunction

    // Accumulate stage runs one cycle behind address issue; relu is taken at that point
    // so a hidden value finalised by the previous accumulate is already visible.
    always_comb begin
        op_a = x;
        if (acc_l2)
            op_a = DATA_W'(relu64(64'(h[acc_j])));
        acc_sel = acc_l2 ? o[acc_k] : h[acc_j];
        o_first = (acc_en && acc_l2 && acc_k == '0) ? mac_out : o[0];
    end

    mlp_seq_accel_mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac_unit (
        .en     (acc_en),
        .a      (op_a),
        .b      (bus.w_data),
        .acc_in (acc_sel),
        .acc_out(mac_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            i             <= '0;
            j             <= '0;
            k             <= '0;
            acc_j         <= '0;
            acc_k         <= '0;
            x             <= '0;
            acc_en        <= 1'b0;
            acc_l2        <= 1'b0;
            for (int unsigned n = 0; n < HID; n++) h[n] <= '0;
            for (int unsigned n = 0; n < OUT; n++) o[n] <= '0;
            bus.busy      <= 1'b0;
            bus.img_ready <= 1'b0;
            bus.w_addr    <= '0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_idx   <= '0;
        end else begin
            acc_en <= 1'b0;
            if (acc_en) begin
                if (acc_l2) o[acc_k] <= mac_out;
                else        h[acc_j] <= mac_out;
            end
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        for (int unsigned n = 0; n < HID; n++) h[n] <= '0;
                        for (int unsigned n = 0; n < OUT; n++) o[n] <= '0;
                        i             <= '0;
                        bus.busy      <= 1'b1;
                        bus.img_ready <= 1'b1;
                        state         <= ST_L1_LOAD;
                    end
                end
                ST_L1_LOAD: begin
                    if (bus.img_valid) begin
                        x             <= bus.img_data;
                        bus.img_ready <= 1'b0;
                        j             <= '0;
                        bus.w_addr    <= l1_addr(32'(i), 0);
                        state         <= ST_L1_MAC;
                    end
                end
                ST_L1_MAC: begin
                    acc_en <= 1'b1;
                    acc_l2 <= 1'b0;
                    acc_j  <= j;
                    if (j == J_W'(HID-1)) begin
                        if (i == I_W'(IN_LEN-1)) begin
                            j          <= '0;
                            k          <= '0;
                            bus.w_addr <= l2_addr(0, 0);
                            state      <= ST_L2_MAC;
                        end else begin
                            i             <= i + 1'b1;
                            bus.img_ready <= 1'b1;
                            state         <= ST_L1_LOAD;
                        end
                    end else begin
                        j          <= j + 1'b1;
                        bus.w_addr <= l1_addr(32'(i), 32'(j) + 1);
                    end
                end
                ST_L2_MAC: begin
                    acc_en <= 1'b1;
                    acc_l2 <= 1'b1;
                    acc_j  <= j;
                    acc_k  <= k;
                    if (k == IDX_W'(OUT-1)) begin
                        k <= '0;
                        if (j == J_W'(HID-1)) begin
                            state <= ST_L2_DRAIN;
                        end else begin
                            j          <= j + 1'b1;
                            bus.w_addr <= l2_addr(32'(j) + 1, 0);
                        end
                    end else begin
                        k          <= k + 1'b1;
                        bus.w_addr <= l2_addr(32'(j), 32'(k) + 1);
                    end
                end
                ST_L2_DRAIN: begin
                    // o[0] may be the accumulate landing this very edge when OUT == 1.
                    k             <= '0;
                    bus.res_valid <= 1'b1;
                    bus.res_data  <= o_first;
                    bus.res_idx   <= '0;
                    state         <= ST_RESULT;
                end
                ST_RESULT: begin
                    if (bus.res_ready) begin
                        if (k == IDX_W'(OUT-1)) begin
                            bus.busy      <= 1'b0;
                            bus.res_valid <= 1'b0;
                            state         <= ST_IDLE;
                        end else begin
                            k            <= k + 1'b1;
                            bus.res_idx  <= k + 1'b1;
                            bus.res_data <= o[k + 1'b1];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MLP_ARGMAX_EN
    logic signed [ACC_W-1:0] max_val;
    logic [IDX_W-1:0]        max_idx;
    logic                    res_fire, better;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        res_fire = (state == ST_RESULT) && bus.res_ready;
        better   = (k == '0) || ($signed(bus.res_data) > max_val);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            max_val         <= '0;
            max_idx         <= '0;
            bus.class_valid <= 1'b0;
            bus.class_idx   <= '0;
        end else begin
            bus.class_valid <= 1'b0;
            if (state == ST_IDLE && bus.start)
                bus.class_idx <= '0;
            if (res_fire) begin
                if (better) begin
                    max_val <= $signed(bus.res_data);
                    max_idx <= k;
                end
                if (k == IDX_W'(OUT-1)) begin
                    bus.class_valid <= 1'b1;
                    bus.class_idx   <= better ? k : max_idx;
                end
            end
        end
    end
`else
    assign bus.class_valid = 1'b0;
    assign bus.class_idx   = '0;
`endif

endmodule

// File: tb/tb_mlp_seq_accel.sv
// Self-checking bench for mlp_seq_accel: directed vector table, corner sequences, randomized images.
module tb_mlp_seq_accel;
    localparam int IL  = 4;
    localparam int HD  = 2;
    localparam int OT  = 3;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int WAW = 4;
    localparam int IXW = 2;
    localparam int LAT = 1 + IL*(HD+1) + HD*OT + 1;

    typedef struct packed {
        logic [IL-1:0][31:0]    px;
        logic [IL*HD-1:0][31:0] w1;
        logic [HD*OT-1:0][31:0] w2;
        logic [OT-1:0][31:0]    want;
        logic [31:0]            want_cls;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mlp_seq_accel_if #(.DATA_W(DW), .ACC_W(AW), .WA_W(WAW), .IDX_W(IXW)) bus ();

    mlp_seq_accel #(.IN_LEN(IL), .HID(HD), .OUT(OT), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [31:0] wmem [16];
    always @(posedge clk) bus.w_data <= wmem[bus.w_addr];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t fill(input int p0, input int p1, input int p2, input int p3,
                                  input int w1v, input int w2v);
        vec_t v = '0;
        v.px[0] = p0; v.px[1] = p1; v.px[2] = p2; v.px[3] = p3;
        for (int n = 0; n < IL*HD; n++) v.w1[n] = w1v;
        for (int n = 0; n < HD*OT; n++) v.w2[n] = w2v;
        return v;
    endfunction

    // Reference: plain 32-bit integer arithmetic wraps exactly like the accumulators.
    function automatic vec_t model(input vec_t v);
        int hv [HD];
        int ov [OT];
        int best;
        for (int jj = 0; jj < HD; jj++) begin
            hv[jj] = 0;
            for (int ii = 0; ii < IL; ii++) hv[jj] += int'(v.px[ii]) * int'(v.w1[ii*HD+jj]);
        end
        for (int kk = 0; kk < OT; kk++) begin
            ov[kk] = 0;
            for (int jj = 0; jj < HD; jj++) ov[kk] += (hv[jj] < 0 ? 0 : hv[jj]) * int'(v.w2[jj*OT+kk]);
        end
        best = 0;
        for (int kk = 1; kk < OT; kk++) if (ov[kk] > ov[best]) best = kk;
        for (int kk = 0; kk < OT; kk++) v.want[kk] = ov[kk];
        v.want_cls = best;
        return v;
    endfunction

    task automatic load_mem(input vec_t v);
        for (int n = 0; n < IL*HD; n++) wmem[n] = v.w1[n];
        for (int n = 0; n < HD*OT; n++) wmem[IL*HD+n] = v.w2[n];
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"},        64'(bus.busy),        64'd0);
        chk({tag, "_img_ready"},   64'(bus.img_ready),   64'd0);
        chk({tag, "_w_addr"},      64'(bus.w_addr),      64'd0);
        chk({tag, "_res_valid"},   64'(bus.res_valid),   64'd0);
        chk({tag, "_res_data"},    64'(bus.res_data),    64'd0);
        chk({tag, "_res_idx"},     64'(bus.res_idx),     64'd0);
        chk({tag, "_class_valid"}, 64'(bus.class_valid), 64'd0);
        chk({tag, "_class_idx"},   64'(bus.class_idx),   64'd0);
    endtask

    task automatic run_image(input vec_t v, input bit stall, input bit chk_lat, input int hold_at);
        int  cyc   = 0;
        int  pix   = 0;
        int  rn    = 0;
        int  first = -1;
        int  held  = 0;
        bit  early = 1'b0;
        load_mem(v);
        @(negedge clk);
        bus.start = 1'b1; bus.img_valid = 1'b0; bus.res_ready = 1'b0;
        while (rn < OT && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            bus.start     = stall && ($urandom_range(0, 7) == 0);
            bus.img_valid = (pix < IL) && (!stall || $urandom_range(0, 3) != 0);
            bus.img_data  = (pix < IL) ? v.px[pix] : '0;
            bus.res_ready = !stall || ($urandom_range(0, 2) != 0);
            if (cyc == 1) begin
                chk("busy_after_start",  64'(bus.busy),      64'd1);
                chk("class_idx_cleared", 64'(bus.class_idx), 64'd0);
            end
            if (bus.class_valid) early = 1'b1;
            if (bus.img_valid && bus.img_ready) pix++;
            if (bus.res_valid) begin
                if (first < 0) begin
                    first = cyc;
                    if (chk_lat) chk("first_result_latency", 64'(cyc), 64'(LAT));
                end
                if (rn == hold_at && held < 5) begin
                    bus.res_ready = 1'b0;
                    held++;
                    chk("hold_res_valid", 64'(bus.res_valid), 64'd1);
                    chk("hold_res_data",  64'(bus.res_data),  64'(v.want[rn]));
                    chk("hold_res_idx",   64'(bus.res_idx),   64'(rn));
                end
                if (bus.res_ready) begin
                    chk("res_data", 64'(bus.res_data), 64'(v.want[rn]));
                    chk("res_idx",  64'(bus.res_idx),  64'(rn));
                    rn++;
                end
            end
        end
        if (rn < OT) begin
            chk("result_timeout", 64'(rn), 64'(OT));
            bus.start = 1'b0; bus.img_valid = 1'b0; bus.res_ready = 1'b0;
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
        end else begin
            chk("class_valid_before_end", 64'(early), 64'd0);
            @(negedge clk);
            bus.start = 1'b0; bus.img_valid = 1'b0; bus.res_ready = 1'b0;
            chk("busy_after_last",      64'(bus.busy),      64'd0);
            chk("res_valid_after_last", 64'(bus.res_valid), 64'd0);
`ifdef MLP_ARGMAX_EN
            chk("class_valid_pulse", 64'(bus.class_valid), 64'd1);
            chk("class_idx",         64'(bus.class_idx),   64'(v.want_cls));
            @(negedge clk);
            chk("class_valid_drop",  64'(bus.class_valid), 64'd0);
            chk("class_idx_held",    64'(bus.class_idx),   64'(v.want_cls));
`else
            chk("class_valid_off", 64'(bus.class_valid), 64'd0);
            chk("class_idx_off",   64'(bus.class_idx),   64'd0);
            @(negedge clk);
            chk("class_valid_off2", 64'(bus.class_valid), 64'd0);
`endif
        end
    endtask

    // Abort an image while the MAC is working on the second pixel.
    task automatic reset_mid(input vec_t v);
        int pix = 0;
        load_mem(v);
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.start     = 1'b0;
            bus.img_valid = (pix < IL);
            bus.img_data  = v.px[pix];
            bus.res_ready = 1'b0;
            if (bus.img_valid && bus.img_ready) pix++;
        end
        chk("mid_busy",   64'(bus.busy),   64'd1);
        chk("mid_w_addr", 64'(bus.w_addr), 64'(HD));
        reset = 1'b1;
        bus.img_valid = 1'b0;
        @(negedge clk);
        check_zero_outputs("mid_reset");
        reset = 1'b0;
    endtask

    vec_t tbl [6];
    vec_t rv;

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.img_valid = 1'b0; bus.img_data = '0; bus.res_ready = 1'b0;
        for (int n = 0; n < 16; n++) wmem[n] = '0;

        tbl[0] = fill(1, 2, 3, 4, 1, 1);
        for (int n = 0; n < OT; n++) tbl[0].want[n] = 20;
        tbl[0].want_cls = 0;
        tbl[1] = fill(1, 2, 3, 4, -1, 1);
        for (int n = 0; n < OT; n++) tbl[1].want[n] = 0;
        tbl[1].want_cls = 0;
        tbl[2] = fill(1, 0, 0, 0, 1, 0);
        tbl[2].w2[0] = 5; tbl[2].w2[1] = 9; tbl[2].w2[2] = 9;
        tbl[2].want[0] = 5; tbl[2].want[1] = 9; tbl[2].want[2] = 9;
        tbl[2].want_cls = 1;
        tbl[3] = fill(2, 2, 2, 2, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        for (int n = 0; n < OT; n++) tbl[3].want[n] = 0;
        tbl[3].want_cls = 0;
        tbl[4] = fill(1, 0, 0, 0, 32'h7FFF_FFFF, 2);
        for (int n = 0; n < OT; n++) tbl[4].want[n] = 32'hFFFF_FFFC;
        tbl[4].want_cls = 0;
        tbl[5] = fill(1, 0, 0, 0, 1, 0);
        tbl[5].w2[0] = -3; tbl[5].w2[1] = 7; tbl[5].w2[2] = -1;
        tbl[5].want[0] = -3; tbl[5].want[1] = 7; tbl[5].want[2] = -1;
        tbl[5].want_cls = 1;

        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;

        for (int t = 0; t < 6; t++) run_image(tbl[t], 1'b0, t == 0, -1);

        run_image(tbl[0], 1'b0, 1'b0, 1);

        reset_mid(tbl[0]);
        run_image(tbl[0], 1'b0, 1'b1, -1);

        for (int r = 0; r < 6; r++) begin
            rv = '0;
            for (int n = 0; n < IL; n++)
                rv.px[n] = (r < 3) ? $urandom_range(0, 40) - 20 : $urandom;
            for (int n = 0; n < IL*HD; n++)
                rv.w1[n] = (r < 3) ? $urandom_range(0, 40) - 20 : $urandom;
            for (int n = 0; n < HD*OT; n++)
                rv.w2[n] = (r < 3) ? $urandom_range(0, 40) - 20 : $urandom;
            rv = model(rv);
            run_image(rv, 1'b1, 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mlp_seq_accel.md
# mlp_seq_accel

Parametrised, time-multiplexed two-layer MLP inference engine (dense → ReLU → dense) replacing the fixed 32-hidden/10-output systolic top. Accepts pixels over a valid/ready stream, fetches weights one per cycle from an external synchronous weight memory through a single MAC datapath, and returns class scores sequentially over a valid/ready stream. Sits between the picoRV32 peripheral bus adapter and the weight/bias ROM.

## Interface
- IN_LEN, 784, pixels per image
- HID, 32, hidden neurons
- OUT, 10, output classes
- DATA_W, 32, pixel/weight width, signed two's complement
- ACC_W, 32, accumulator width
- WA_W, $clog2(IN_LEN*HID+HID*OUT), weight address width
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin an image
- busy  out  1  high from accepted start until final result handshake
- img_valid / img_ready / img_data  in / out / in  1 / 1 / DATA_W  pixel stream
- w_addr  out  WA_W  weight read address
- w_data  in  DATA_W  weight, valid exactly one cycle after w_addr
- res_valid / res_ready  out / in  1 / 1  result stream handshake
- res_data  out  ACC_W  class score
- res_idx  out  $clog2(OUT)  class index of res_data
- class_valid  out  1  one-cycle argmax pulse
- class_idx  out  $clog2(OUT)  argmax class

## Operation
- States: IDLE, L1_LOAD, L1_MAC, L2_MAC, L2_DRAIN, RESULT.
- IDLE: start=1 → clear all HID+OUT accumulators, i=0, → L1_LOAD. start outside IDLE ignored.
- L1_LOAD: img_ready=1; on img_valid capture pixel x, → L1_MAC.
- L1_MAC: HID cycles, issue w_addr = i*HID + j, j=0..HID-1; the following cycle h[j] += x*w_data. Then i++; i<IN_LEN → L1_LOAD, else → L2_MAC.
- L2_MAC: HID*OUT cycles, j outer, k inner, w_addr = IN_LEN*HID + j*OUT + k; next cycle o[k] += relu(h[j])*w_data. → L2_DRAIN (one cycle, last accumulate lands) → RESULT, k=0.
- relu(h) = h<0 ? 0 : h, then low DATA_W bits used as operand.
- Products are full 2*DATA_W signed; accumulate wraps modulo 2^ACC_W (no saturation).
- RESULT: res_valid=1, res_data=o[k], res_idx=k, stable until res_ready. On handshake k++; after k=OUT-1 handshake → IDLE, busy drops same edge.
- reset in any state: → IDLE, accumulators, counters and all outputs to 0; in-flight image discarded.

## Timing
- All outputs registered; reset value 0 for busy, img_ready, w_addr, res_valid, res_data, res_idx, class_valid, class_idx.
- Per pixel: 1 L1_LOAD cycle (when img_valid already high) + HID L1_MAC cycles; last layer-1 accumulate overlaps the next L1_LOAD/L2_MAC first cycle.
- Minimum start → first res_valid: 1 + IN_LEN*(HID+1) + HID*OUT + 1 cycles.
- img_valid low stalls in L1_LOAD indefinitely; no timeout. res_ready low stalls RESULT indefinitely.
- img_valid while not in L1_LOAD: not consumed (img_ready=0).
- w_addr holds its last value outside MAC states.

## Configuration
- MLP_ARGMAX_EN defined: running max tracked over emitted results (strict >, ties keep lowest index); class_valid pulses the cycle after the final result handshake with class_idx; class_idx held until next accepted start.
- Undefined: class_valid and class_idx tied 0, no comparator logic.

## Structure
- Package mlp_seq_accel_pkg: state enum, weight base-offset function (layer-2 base = IN_LEN*HID), relu function.
- One sub-module: mac_unit (signed DATA_W×DATA_W multiply, ACC_W wrap-add, enable).

## Test plan
- IN_LEN=4, HID=2, OUT=3, all weights 1, pixels 1,2,3,4 → results 20,20,20 at res_idx 0,1,2.
- Layer-1 weights −1, pixels 1..4 → hidden −10 relu'd to 0 → all results 0.
- res_ready held low 5 cycles at k=1 → res_valid, res_data, res_idx stable throughout; k=2 follows after handshake.
- reset asserted mid-L1_MAC → next cycle busy=0, all outputs 0; new start with same stimulus → identical results.
- MLP_ARGMAX_EN, results 5,9,9 → class_valid one-cycle pulse, class_idx=1; undefined → class_valid never 1.
- Weights 0x7FFFFFFF, pixel 2 → accumulator wraps modulo 2^32, matches model.
